// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with valid/ready handshakes on operands and result.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // 1-bit full-subtractor cell, returns {borrow_out, difference}
  function automatic logic [1:0] sub_cell(input logic ai, input logic bi, input logic br);
    logic d;
    logic bo;
    d  = ai ^ bi ^ br;
    bo = (~ai & bi) | (~(ai ^ bi) & br);
    return {bo, d};
  endfunction

  state_t           state_r;
  state_t           state_n_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_sh_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;
  logic [1:0]       cell_s;
  logic             accept_s;
  logic             release_s;

  assign cell_s    = sub_cell(a_sh_r[0], b_sh_r[0], br_r);
  assign accept_s  = (state_r == IDLE) && in_valid && in_ready_r;
  assign release_s = (state_r == DONE) && out_valid_r && out_ready;

  // Next-state logic
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_n_s = BUSY;
        else          state_n_s = IDLE;
      end
      BUSY: begin
        if (cnt_r == LAST) state_n_s = DONE;
        else               state_n_s = BUSY;
      end
      DONE: begin
        if (release_s) state_n_s = IDLE;
        else           state_n_s = DONE;
      end
      default: state_n_s = IDLE;
    endcase
  end

  // State register and handshake outputs; out_valid rises one clock after DONE is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      in_ready_r  <= (state_n_s == IDLE);
      out_valid_r <= (state_r == DONE) && !release_s;
    end
  end

  // Serial datapath: operand shifters, borrow chain and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r    <= {WIDTH{1'b0}};
      b_sh_r    <= {WIDTH{1'b0}};
      diff_sh_r <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      br_r      <= 1'b0;
      diff_r    <= {WIDTH{1'b0}};
      bout_r    <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_sh_r    <= a;
            b_sh_r    <= b;
            br_r      <= bin;
            cnt_r     <= {CW{1'b0}};
            diff_sh_r <= {WIDTH{1'b0}};
          end
        end
        BUSY: begin
          a_sh_r    <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r    <= {1'b0, b_sh_r[WIDTH-1:1]};
          diff_sh_r <= {cell_s[0], diff_sh_r[WIDTH-1:1]};
          br_r      <= cell_s[1];
          cnt_r     <= cnt_r + CW'(1);
          // br_r here is the borrow into the MSB; overflow is its mismatch with the final borrow
          if (cnt_r == LAST) begin
            diff_r <= {cell_s[0], diff_sh_r[WIDTH-1:1]};
            bout_r <= cell_s[1];
            ovf_r  <= br_r ^ cell_s[1];
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): arithmetic, latency,
// backpressure and mid-operation reset.
module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] diff;
  logic       bout;
  logic       ovf;

  int checks;
  int failures;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ready_timeout"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Accept one operation, measure latency and check the result
  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic tbin, input logic [3:0] ediff, input logic ebout,
                        input logic eovf, input logic early_ready);
    int lat;
    wait_ready(tag);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = early_ready;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (lat == 0) begin
        if (out_valid) lat = k - 1;
        else step();
      end
    end
    check({tag, "_latency"}, lat, 32'd5);
    check({tag, "_diff"}, {28'd0, diff}, {28'd0, ediff});
    check({tag, "_bout"}, {31'd0, bout}, {31'd0, ebout});
    check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, eovf});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 4'd0; b = 4'd0; bin = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff",      {28'd0, diff},      32'd0);
    check("rst_bout",      {31'd0, bout},      32'd0);
    check("rst_ovf",       {31'd0, ovf},       32'd0);

    run_op("t1", 4'd7, 4'd3, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0);
    run_op("t2", 4'd3, 4'd7, 1'b0, 4'hC,  1'b1, 1'b0, 1'b1);
    run_op("t3", 4'd8, 4'd1, 1'b0, 4'd7,  1'b0, 1'b1, 1'b0);
    run_op("t4", 4'd0, 4'd0, 1'b1, 4'hF,  1'b1, 1'b0, 1'b0);
    run_op("t7", 4'd7, 4'hF, 1'b0, 4'd8,  1'b1, 1'b1, 1'b0);

    // Backpressure: 9 - 2 -> 7 with signed overflow, held while out_ready=0
    wait_ready("t5");
    a = 4'd9; b = 4'd2; bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("t5_valid", {31'd0, out_valid}, 32'd1);
    a = 4'd5; b = 4'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t5_hold_ready", {31'd0, in_ready},  32'd0);
      check("t5_hold_diff",  {28'd0, diff},      32'd7);
      check("t5_hold_bout",  {31'd0, bout},      32'd0);
      check("t5_hold_ovf",   {31'd0, ovf},       32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t5_release_valid", {31'd0, out_valid}, 32'd0);
    check("t5_release_ready", {31'd0, in_ready},  32'd1);
    step();
    check("t5_idle_diff_kept", {28'd0, diff}, 32'd7);
    check("t5_idle_no_accept", {31'd0, in_ready}, 32'd1);

    // Reset two clocks after accept
    wait_ready("t6");
    a = 4'd7; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_in_ready",  {31'd0, in_ready},  32'd1);
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_diff",      {28'd0, diff},      32'd0);
    for (int k = 0; k < 6; k++) step();
    check("t6_no_result", {31'd0, out_valid}, 32'd0);
    run_op("t6b", 4'd5, 4'd6, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
